shift_sub_divider: RTL



---
 rtl/shift_sub_divider.sv | 121 ++++++++++++
 1 files changed

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring (shift-subtract) unsigned divider.
// The divider accepts a dividend/divisor pair on a valid/acknowledge handshake.
// It produces one quotient bit per clock.
// It holds the quotient and remainder with oDone asserted until iAck arrives.
module shift_sub_divider #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iValid_Data,
    input  logic             iAck,
    input  logic [WIDTH-1:0] iData_A,
    input  logic [WIDTH-1:0] iData_B,
    output logic [WIDTH-1:0] oQuotient,
    output logic [WIDTH-1:0] oRemainder,
    output logic             oDone,
    output logic             oBusy,
    output logic             oDivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic             dz_q;

    logic [WIDTH:0]   rem_t;
    logic [WIDTH:0]   rem_sub;
    logic             qbit;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic             last_iter;

    // One restoring step; the compare is WIDTH+1 bits wide so large divisors cannot overflow it.
    always_comb begin
        rem_t     = {rem_q, dvd_q[WIDTH-1]};
        rem_sub   = rem_t - {1'b0, dvs_q};
        qbit      = (rem_t >= {1'b0, dvs_q});
        rem_d     = qbit ? rem_sub[WIDTH-1:0] : rem_t[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], qbit};
        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            dz_q       <= 1'b0;
            oQuotient  <= '0;
            oRemainder <= '0;
            oDone      <= 1'b0;
            oBusy      <= 1'b0;
            oDivZero   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                    if (iValid_Data) begin
                        dvd_q   <= iData_A;
                        dvs_q   <= iData_B;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        dz_q    <= (iData_B == '0);
                        oBusy   <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    // A zero divisor spends exactly one CALC cycle, giving the one-edge divide-by-zero latency.
                    if (dz_q) begin
                        oQuotient  <= '1;
                        oRemainder <= dvd_q;
                        oDivZero   <= 1'b1;
                        oDone      <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                        cnt_q <= cnt_q + 1'b1;
                        if (last_iter) begin
                            oQuotient  <= quo_d;
                            oRemainder <= rem_d;
                            oDivZero   <= 1'b0;
                            oDone      <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (iAck) begin
                        oDone   <= 1'b0;
                        oBusy   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
